// File: rtl/fetch_arbiter_ctrl_if.sv
// Bus bundle between fetch_arbiter_ctrl and its neighbours: PC/branch logic,
// decode, the load unit and the instruction ROM read port.
interface fetch_arbiter_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              stall_i;
    logic              redirect_i;
    logic [31:0]       redirect_pc_i;
    logic              dreq_valid_i;
    logic [ADDR_W-1:0] dreq_addr_i;
    logic              dreq_ready_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [31:0]       rom_data_i;
    logic [31:0]       inst_o;
    logic [31:0]       inst_pc_o;
    logic              inst_valid_o;
    logic              drsp_valid_o;
    logic [31:0]       drsp_data_o;

    // Controller side
    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, dreq_valid_i, dreq_addr_i, rom_data_i,
        output dreq_ready_o, rom_addr_o, inst_o, inst_pc_o, inst_valid_o,
        output drsp_valid_o, drsp_data_o
    );

    // Environment side (pipeline, load unit, ROM)
    modport master (
        output stall_i, redirect_i, redirect_pc_i, dreq_valid_i, dreq_addr_i, rom_data_i,
        input  dreq_ready_o, rom_addr_o, inst_o, inst_pc_o, inst_valid_o,
        input  drsp_valid_o, drsp_data_o
    );
endinterface

// File: rtl/fetch_arbiter_ctrl.sv
// Fetch / data arbiter for the single-port synchronous instruction ROM.
// Owns the fetch PC, applies redirects, tags every ROM access so the
// returning word is routed to decode or to the load unit, and absorbs
// decode back-pressure with a one-entry skid buffer.
module fetch_arbiter_ctrl #(
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic                 clk,
    input logic                 rst,
    fetch_arbiter_ctrl_if.slave bus
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic RR_FETCH = 1'b0;
    localparam logic RR_DATA  = 1'b1;

    logic [1:0]        state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              rr_q, rr_d;
    logic              epoch_q, epoch_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    logic              tag_valid_q, tag_valid_d;
    logic              tag_data_q, tag_data_d;
    logic [31:0]       tag_pc_q, tag_pc_d;
    logic              tag_epoch_q, tag_epoch_d;

    logic              skid_valid_q, skid_valid_d;
    logic [31:0]       skid_inst_q, skid_inst_d;
    logic [31:0]       skid_pc_q, skid_pc_d;

    logic [31:0]       inst_q, inst_d;
    logic [31:0]       inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              drsp_valid_q, drsp_valid_d;
    logic [31:0]       drsp_data_q, drsp_data_d;

    logic              fetch_elig, data_elig;
    logic              grant_fetch, grant_data;
    logic [31:0]       issue_pc;
    logic              fetch_ret;

    assign fetch_elig = (state_q == ST_RUN) && !bus.stall_i;
    assign data_elig  = bus.dreq_valid_i && (state_q != ST_BOOT);

    // A word returning this cycle belongs to decode only if it was issued in the
    // current epoch and no redirect is flushing the stream right now.
    assign fetch_ret = tag_valid_q && !tag_data_q && (tag_epoch_q == epoch_q) && !bus.redirect_i;

    // Pick this cycle's ROM owner: redirect first (even during boot, so a
    // redirect is never lost), then round-robin when both sides want the port.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        issue_pc    = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q;
        rr_d        = rr_q;
        if (bus.redirect_i) begin
            grant_fetch = 1'b1;
            issue_pc    = bus.redirect_pc_i;
            fetch_pc_d  = bus.redirect_pc_i + 32'd4;
        end else if (fetch_elig && data_elig) begin
            if (rr_q == RR_FETCH) begin
                grant_data = 1'b1;
                rr_d       = RR_DATA;
            end else begin
                grant_fetch = 1'b1;
                rr_d        = RR_FETCH;
            end
        end else if (fetch_elig) begin
            grant_fetch = 1'b1;
        end else if (data_elig) begin
            grant_data = 1'b1;
        end
        if (grant_fetch && !bus.redirect_i) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (grant_fetch) begin
            rom_addr_d = issue_pc[ADDR_W+1:2];
        end else if (grant_data) begin
            rom_addr_d = bus.dreq_addr_i;
        end else begin
            rom_addr_d = rom_addr_q;
        end
        epoch_d     = epoch_q ^ bus.redirect_i;
        tag_valid_d = grant_fetch || grant_data;
        tag_data_d  = grant_data;
        tag_pc_d    = issue_pc;
        tag_epoch_d = epoch_d;
    end

    // Route returning fetch words into decode or the skid; the skid always drains first.
    always_comb begin
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        if (bus.redirect_i) begin
            inst_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!bus.stall_i) begin
            if (skid_valid_q) begin
                inst_d       = skid_inst_q;
                inst_pc_d    = skid_pc_q;
                inst_valid_d = 1'b1;
                skid_valid_d = fetch_ret;
                skid_inst_d  = bus.rom_data_i;
                skid_pc_d    = tag_pc_q;
            end else if (fetch_ret) begin
                inst_d       = bus.rom_data_i;
                inst_pc_d    = tag_pc_q;
                inst_valid_d = 1'b1;
            end else begin
                inst_valid_d = 1'b0;
            end
        end else if (fetch_ret) begin
            if (!inst_valid_q) begin
                inst_d       = bus.rom_data_i;
                inst_pc_d    = tag_pc_q;
                inst_valid_d = 1'b1;
            end else begin
                skid_valid_d = 1'b1;
                skid_inst_d  = bus.rom_data_i;
                skid_pc_d    = tag_pc_q;
            end
        end
    end

    // Data responses are never flushed; the data word simply latches until the next one.
    always_comb begin
        drsp_valid_d = tag_valid_q && tag_data_q;
        drsp_data_d  = drsp_valid_d ? bus.rom_data_i : drsp_data_q;
    end

    // BOOT lasts one cycle; afterwards HOLD simply mirrors a full skid so no fetch can overflow it.
    always_comb begin
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            default: state_d = skid_valid_d ? ST_HOLD : ST_RUN;
        endcase
    end

    // State registers; reset drops every in-flight tag so nothing is delivered afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_BOOT;
            fetch_pc_q   <= RESET_PC;
            rr_q         <= RR_FETCH;
            epoch_q      <= 1'b0;
            rom_addr_q   <= '0;
            tag_valid_q  <= 1'b0;
            tag_data_q   <= 1'b0;
            tag_pc_q     <= 32'h0;
            tag_epoch_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= 32'h0;
            skid_pc_q    <= 32'h0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            drsp_valid_q <= 1'b0;
            drsp_data_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            rr_q         <= rr_d;
            epoch_q      <= epoch_d;
            rom_addr_q   <= rom_addr_d;
            tag_valid_q  <= tag_valid_d;
            tag_data_q   <= tag_data_d;
            tag_pc_q     <= tag_pc_d;
            tag_epoch_q  <= tag_epoch_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            drsp_valid_q <= drsp_valid_d;
            drsp_data_q  <= drsp_data_d;
        end
    end

    assign bus.rom_addr_o   = rom_addr_d;
    assign bus.dreq_ready_o = grant_data;
    assign bus.inst_o       = inst_q;
    assign bus.inst_pc_o    = inst_pc_q;
    assign bus.inst_valid_o = inst_valid_q;
    assign bus.drsp_valid_o = drsp_valid_q;
    assign bus.drsp_data_o  = drsp_data_q;

endmodule

// File: tb/tb_fetch_arbiter_ctrl.sv
// Self-checking bench for fetch_arbiter_ctrl. A behavioural model tracks the
// expected in-order instruction stream (by byte PC, restarted on redirect or
// reset) and a queue of expected data responses due two cycles after grant.
module tb_fetch_arbiter_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_arbiter_ctrl_if #(.ADDR_W(14)) bus ();

    fetch_arbiter_ctrl #(
        .ADDR_W  (14),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Instruction ROM: ROM[k] = k + 0x100, one-cycle read latency
    always @(posedge clk) bus.rom_data_i <= 32'h100 + {18'd0, bus.rom_addr_o};

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          idle        = 0;
    int          denied      = 0;
    int          accepted    = 0;
    logic [31:0] exp_pc      = 32'h0;

    logic        r_st, r_rd, r_dv;
    logic [31:0] r_pc;
    logic [13:0] r_da;

    function automatic logic [31:0] rom_word(input logic [13:0] a);
        return 32'h100 + {18'd0, a};
    endfunction

    // Single comparison point for the whole bench
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs, then check outputs against the reference model
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic dv, input logic [13:0] da);
        logic exp_drsp;
        logic [31:0] tmp_pc;
        @(negedge clk);
        bus.stall_i       = st;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.dreq_valid_i  = dv;
        bus.dreq_addr_i   = da;
        #3;
        // instruction stream: every accepted word must be the next PC in program order
        if (bus.inst_valid_o && !st) begin
            tmp_pc = exp_pc;
            check_output("inst_pc", bus.inst_pc_o, tmp_pc);
            check_output("inst_word", bus.inst_o, rom_word(tmp_pc[15:2]));
            exp_pc = exp_pc + 32'd4;
            accepted++;
            idle = 0;
        end else if (!st) begin
            idle++;
        end
        check_output("fetch_progress", 32'(idle > 16), 32'd0);
        if (rd) begin
            exp_pc = rpc;
            idle   = 0;
        end
        // data responses arrive exactly two cycles after their grant
        exp_drsp = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
        check_output("drsp_valid", 32'(bus.drsp_valid_o), 32'(exp_drsp));
        if (exp_drsp) begin
            check_output("drsp_data", bus.drsp_data_o, rsp_q[0].data);
            void'(rsp_q.pop_front());
        end
        check_output("ready_qual", 32'(bus.dreq_ready_o && !(dv && !rd)), 32'd0);
        if (bus.dreq_ready_o && dv) rsp_q.push_back('{due: cyc + 2, data: rom_word(da)});
        denied = (dv && !rd && !bus.dreq_ready_o) ? denied + 1 : 0;
        check_output("dreq_fair", 32'(denied >= 2), 32'd0);
        cyc++;
    endtask

    // Assert reset mid-cycle, confirm outputs clear at once and stay quiet, then release
    task automatic do_reset();
        @(negedge clk);
        rst               = 1'b0;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.dreq_valid_i  = 1'b0;
        bus.dreq_addr_i   = 14'h0;
        #1;
        check_output("rst_inst", bus.inst_o, 32'h0);
        check_output("rst_inst_pc", bus.inst_pc_o, 32'h0);
        check_output("rst_inst_valid", 32'(bus.inst_valid_o), 32'd0);
        check_output("rst_drsp_valid", 32'(bus.drsp_valid_o), 32'd0);
        check_output("rst_drsp_data", bus.drsp_data_o, 32'h0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check_output("rst_hold_drsp", 32'(bus.drsp_valid_o), 32'd0);
            check_output("rst_hold_inst", 32'(bus.inst_valid_o), 32'd0);
        end
        rsp_q.delete();
        exp_pc = 32'h0;
        idle   = 0;
        denied = 0;
        rst    = 1'b1;
    endtask

    initial begin
        rst               = 1'b0;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.dreq_valid_i  = 1'b0;
        bus.dreq_addr_i   = 14'h0;
        do_reset();

        // T1 boot and streaming, then T3 redirect to 0x40 while 0x10 is stalled
        for (int i = 0; i < 10; i++) begin
            step((i == 6 || i == 7), (i == 7), 32'h40, 1'b0, 14'h0);
            if (i < 2) begin
                check_output("t1_boot_invalid", 32'(bus.inst_valid_o), 32'd0);
            end else if (i <= 6) begin
                check_output("t1_valid", 32'(bus.inst_valid_o), 32'd1);
                check_output("t1_pc", bus.inst_pc_o, 32'(4 * (i - 2)));
                check_output("t1_inst", bus.inst_o, 32'(32'h100 + (i - 2)));
            end else if (i == 7) begin
                check_output("t3_held_pc", bus.inst_pc_o, 32'h10);
            end else if (i == 8) begin
                check_output("t3_flush", 32'(bus.inst_valid_o), 32'd0);
            end else begin
                check_output("t3_valid", 32'(bus.inst_valid_o), 32'd1);
                check_output("t3_pc", bus.inst_pc_o, 32'h40);
                check_output("t3_inst", bus.inst_o, 32'h110);
            end
        end

        // T2 three-cycle stall: 0x50 must stay frozen on the output
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 14'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 14'h0);
            check_output("t2_frozen_valid", 32'(bus.inst_valid_o), 32'd1);
            check_output("t2_frozen_pc", bus.inst_pc_o, 32'h50);
            check_output("t2_frozen_inst", bus.inst_o, 32'h114);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 14'h0);

        // T4 continuous data requests alternate with fetch
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 14'd5);
            check_output("t4_ready", 32'(bus.dreq_ready_o), 32'((i % 2) == 0));
            if (i == 2 || i == 4) begin
                check_output("t4_drsp_valid", 32'(bus.drsp_valid_o), 32'd1);
                check_output("t4_drsp_data", bus.drsp_data_o, 32'h105);
            end
        end

        // T5 data request colliding with a redirect
        step(1'b1, 1'b0, 32'h0, 1'b1, 14'd7);
        check_output("t5_pre_ready", 32'(bus.dreq_ready_o), 32'd1);
        step(1'b0, 1'b1, 32'h200, 1'b1, 14'd9);
        check_output("t5_redir_ready", 32'(bus.dreq_ready_o), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 14'd9);
        check_output("t5_next_ready", 32'(bus.dreq_ready_o), 32'd1);
        check_output("t5_old_drsp", 32'(bus.drsp_valid_o), 32'd1);
        check_output("t5_old_data", bus.drsp_data_o, 32'h107);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 14'h0);

        // Randomised traffic, including redirects that wrap the PC and the ROM address
        for (int n = 0; n < 1500; n++) begin
            r_st = ($urandom_range(0, 99) < 30);
            r_rd = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 3))
                0:       r_pc = 32'hFFFF_FFF8;
                1:       r_pc = 32'h0000_FFF8;
                default: r_pc = $urandom & 32'hFFFF_FFFC;
            endcase
            r_dv = ($urandom_range(0, 99) < 40);
            r_da = 14'($urandom_range(0, 16383));
            step(r_st, r_rd, r_pc, r_dv, r_da);
        end
        check_output("stream_progress", 32'(accepted > 200), 32'd1);

        // T6 reset with a data request in flight: no response may appear, fetch restarts at 0
        step(1'b1, 1'b0, 32'h0, 1'b1, 14'd3);
        check_output("t6_grant", 32'(bus.dreq_ready_o), 32'd1);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 32'h0, ((i % 5) == 4), 14'(i));
            if (i < 3) check_output("t6_first_valid", 32'(bus.inst_valid_o), 32'(i == 2));
            if (i == 2) begin
                check_output("t6_pc", bus.inst_pc_o, 32'h0);
                check_output("t6_inst", bus.inst_o, 32'h100);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
